// File: rtl/parking_session_controller_pkg.sv
// Shared types and constants for the parking session controller.
package parking_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam int PRICE_W = 5;
  localparam int MIN_W   = 8;

  localparam int DUR_30MIN = 30;
  localparam int DUR_1H    = 60;
  localparam int DUR_2H    = 120;

  localparam int DEF_TICKS_PER_MIN = 60;
  localparam int DEF_MAX_MIN       = 240;
  localparam int DEF_PRICE_30MIN   = 2;
  localparam int DEF_PRICE_1H      = 4;
  localparam int DEF_PRICE_2H      = 7;

  localparam int PRICE_MAX = (1 << PRICE_W) - 1;

  // Price accumulator never wraps; it pins at the largest displayable value.
  function automatic logic [PRICE_W-1:0] sat_price(input int unsigned v);
    return (v > unsigned'(PRICE_MAX)) ? PRICE_W'(PRICE_MAX) : PRICE_W'(v);
  endfunction
endpackage

// File: rtl/parking_session_controller_if.sv
// Station/display signal bundle between the client stations and the controller.
interface parking_session_controller_if;
  import parking_pkg::*;

  logic               ClientA;
  logic               ClientB;
  logic               Button30Min;
  logic               Button1Hour;
  logic               Button2Hours;
  logic               PayDone;
  logic [1:0]         Grant;
  logic [PRICE_W-1:0] ValueToPay;
  logic [MIN_W-1:0]   MinutesLeft;
  logic               P;
  logic               Active;

  modport master (
    output ClientA, ClientB, Button30Min, Button1Hour, Button2Hours, PayDone,
    input  Grant, ValueToPay, MinutesLeft, P, Active
  );

  modport slave (
    input  ClientA, ClientB, Button30Min, Button1Hour, Button2Hours, PayDone,
    output Grant, ValueToPay, MinutesLeft, P, Active
  );
endinterface

// File: rtl/parking_session_controller_minute_timer.sv
// Minutes register with prescaler: holds the selection total, then counts it down.
module minute_timer
  import parking_pkg::*;
#(
  parameter int TICKS_PER_MIN = DEF_TICKS_PER_MIN
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             i_load,
  input  logic [MIN_W-1:0] i_value,
  input  logic             i_run,
  output logic [MIN_W-1:0] o_minutes,
  output logic             o_expired
);
  localparam int PW = $clog2(TICKS_PER_MIN);

  logic [PW-1:0]    r_presc;
  logic [MIN_W-1:0] r_min;
  logic             w_tick;

  assign w_tick    = i_run && (r_presc == PW'(TICKS_PER_MIN - 1));
  // Asserted on the edge that takes the count to zero, so the owner leaves RUN on that same edge.
  assign o_expired = w_tick && (r_min == MIN_W'(1));
  assign o_minutes = r_min;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_presc <= '0;
      r_min   <= '0;
    end else if (i_load) begin
      r_presc <= '0;
      r_min   <= i_value;
    end else if (i_run) begin
      if (w_tick) begin
        r_presc <= '0;
        if (r_min != '0) r_min <= r_min - 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end
endmodule

// File: rtl/parking_session_controller.sv
// Two-station arbiter plus duration/price selection and paid-session countdown.
module parking_session_controller
  import parking_pkg::*;
#(
  parameter int TICKS_PER_MIN = DEF_TICKS_PER_MIN,
  parameter int MAX_MIN       = DEF_MAX_MIN,
  parameter int PRICE_30MIN   = DEF_PRICE_30MIN,
  parameter int PRICE_1H      = DEF_PRICE_1H,
  parameter int PRICE_2H      = DEF_PRICE_2H
) (
  input  logic                         Clk,
  input  logic                         ResetN,
  parking_session_controller_if.slave  bus
);
  state_t             r_state;
  logic [1:0]         r_req;
  logic [2:0]         r_btn;
  logic [2:0]         r_btn_d;
  logic               r_pay;
  logic               r_last_b;
  logic               r_hold;
  logic [1:0]         r_grant;
  logic [PRICE_W-1:0] r_value;
  logic               r_p;
  logic               r_active;

  logic [2:0]         w_rise;
  logic [1:0]         w_pick;
  logic               w_owner_req;
  logic               w_do_grant;
  logic               w_abort;
  logic               w_pay;
  logic               w_add;
  logic               w_fits;
  logic [MIN_W:0]     w_min_add;
  logic [MIN_W:0]     w_min_sum;
  logic [7:0]         w_price_add;
  logic [PRICE_W-1:0] w_value_sum;
  logic [MIN_W-1:0]   w_minutes;
  logic               w_expired;
  logic               w_load;
  logic [MIN_W-1:0]   w_load_val;

  assign w_rise = r_btn & ~r_btn_d;

  assign w_min_add = (w_rise[0] ? (MIN_W+1)'(DUR_30MIN) : '0)
                   + (w_rise[1] ? (MIN_W+1)'(DUR_1H)    : '0)
                   + (w_rise[2] ? (MIN_W+1)'(DUR_2H)    : '0);
  assign w_min_sum = {1'b0, w_minutes} + w_min_add;
  assign w_fits    = w_min_sum <= (MIN_W+1)'(MAX_MIN);

  assign w_price_add = (w_rise[0] ? 8'(PRICE_30MIN) : 8'd0)
                     + (w_rise[1] ? 8'(PRICE_1H)    : 8'd0)
                     + (w_rise[2] ? 8'(PRICE_2H)    : 8'd0);
  assign w_value_sum = sat_price(32'(r_value) + 32'(w_price_add));

  // Round-robin on contention: whoever was not served last wins.
  always_comb begin
    w_pick = 2'b00;
    case (r_req)
      2'b01:   w_pick = 2'b01;
      2'b10:   w_pick = 2'b10;
      2'b11:   w_pick = r_last_b ? 2'b01 : 2'b10;
      default: w_pick = 2'b00;
    endcase
  end

  assign w_owner_req = |(r_req & r_grant);
  assign w_do_grant  = (r_state == ST_IDLE) && !r_hold && (|r_req);
  assign w_abort     = (r_state == ST_SELECT) && !w_owner_req;
  assign w_pay       = (r_state == ST_SELECT) && w_owner_req && r_pay && (r_value != '0);
  assign w_add       = (r_state == ST_SELECT) && w_owner_req && !w_pay && (|w_rise) && w_fits;

  // The timer register doubles as the selection accumulator; reloading on pay restarts the prescaler.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    if (w_do_grant || w_abort) begin
      w_load = 1'b1;
    end else if (w_pay) begin
      w_load     = 1'b1;
      w_load_val = w_minutes;
    end else if (w_add) begin
      w_load     = 1'b1;
      w_load_val = w_min_sum[MIN_W-1:0];
    end
  end

  minute_timer #(.TICKS_PER_MIN(TICKS_PER_MIN)) u_timer (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .i_load    (w_load),
    .i_value   (w_load_val),
    .i_run     (r_state == ST_RUN),
    .o_minutes (w_minutes),
    .o_expired (w_expired)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state  <= ST_IDLE;
      r_req    <= '0;
      r_btn    <= '0;
      r_btn_d  <= '0;
      r_pay    <= 1'b0;
      r_last_b <= 1'b1;
      r_hold   <= 1'b0;
      r_grant  <= '0;
      r_value  <= '0;
      r_p      <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_req   <= {bus.ClientB, bus.ClientA};
      r_btn   <= {bus.Button2Hours, bus.Button1Hour, bus.Button30Min};
      r_btn_d <= r_btn;
      r_pay   <= bus.PayDone;
      case (r_state)
        ST_IDLE: begin
          r_hold <= 1'b0;
          if (w_do_grant) begin
            r_state <= ST_SELECT;
            r_grant <= w_pick;
            r_value <= '0;
            r_p     <= 1'b0;
          end
        end
        ST_SELECT: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_value <= '0;
            r_p     <= 1'b0;
          end else if (w_pay) begin
            r_state  <= ST_RUN;
            r_value  <= '0;
            r_p      <= 1'b0;
            r_active <= 1'b1;
          end else if (w_add) begin
            r_value <= w_value_sum;
            r_p     <= (w_value_sum != '0);
          end
        end
        ST_RUN: begin
          // One idle cycle after a session keeps the freshly released datapath quiet.
          if (w_expired) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
            r_grant  <= '0;
            r_last_b <= r_grant[1];
            r_hold   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Grant       = r_grant;
  assign bus.ValueToPay  = r_value;
  assign bus.MinutesLeft = w_minutes;
  assign bus.P           = r_p;
  assign bus.Active      = r_active;
endmodule

// File: tb/tb_parking_session_controller.sv
// Directed bench for parking_session_controller with a 4-cycle minute.
module tb_parking_session_controller;
  logic Clk;
  logic ResetN;
  int   n_vec = 0;
  int   n_err = 0;

  parking_session_controller_if bus ();

  parking_session_controller #(
    .TICKS_PER_MIN (4),
    .MAX_MIN       (240),
    .PRICE_30MIN   (2),
    .PRICE_1H      (4),
    .PRICE_2H      (7)
  ) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [2:0] m);
    {bus.Button2Hours, bus.Button1Hour, bus.Button30Min} = m;
    cyc(1);
    {bus.Button2Hours, bus.Button1Hour, bus.Button30Min} = 3'b000;
    cyc(1);
  endtask

  task automatic pay();
    bus.PayDone = 1'b1;
    cyc(1);
    bus.PayDone = 1'b0;
    cyc(1);
  endtask

  task automatic run_out(input int exp, input string tag);
    int n;
    n = 0;
    while (bus.Active && n < exp + 50) begin
      cyc(1);
      n++;
    end
    chk(tag, n, exp);
  endtask

  initial begin
    ResetN = 1'b0;
    bus.ClientA = 1'b0; bus.ClientB = 1'b0;
    bus.Button30Min = 1'b0; bus.Button1Hour = 1'b0; bus.Button2Hours = 1'b0;
    bus.PayDone = 1'b0;
    cyc(2);
    chk("rst_grant", bus.Grant, 0);
    chk("rst_value", bus.ValueToPay, 0);
    chk("rst_min", bus.MinutesLeft, 0);
    chk("rst_p", bus.P, 0);
    chk("rst_active", bus.Active, 0);
    ResetN = 1'b1;
    cyc(1);

    // normal session with A alone
    bus.ClientA = 1'b1;
    cyc(1);
    chk("a_grant_lat", bus.Grant, 0);
    cyc(1);
    chk("a_grant", bus.Grant, 1);
    chk("a_p0", bus.P, 0);
    press(3'b010);
    chk("a_value", bus.ValueToPay, 4);
    chk("a_min", bus.MinutesLeft, 60);
    chk("a_p", bus.P, 1);
    pay();
    chk("a_active", bus.Active, 1);
    chk("a_run_p", bus.P, 0);
    chk("a_run_value", bus.ValueToPay, 0);
    chk("a_run_min", bus.MinutesLeft, 60);
    cyc(4);
    chk("a_first_dec", bus.MinutesLeft, 59);
    run_out(236, "a_run_len");
    chk("a_released", bus.Grant, 0);
    cyc(1);
    chk("a_hold_idle", bus.Grant, 0);
    cyc(1);
    chk("a_regrant", bus.Grant, 1);

    // drop and PayDone together: abort wins
    press(3'b001);
    chk("ab_value", bus.ValueToPay, 2);
    bus.ClientA = 1'b0;
    bus.PayDone = 1'b1;
    cyc(1);
    bus.PayDone = 1'b0;
    cyc(1);
    chk("ab_grant", bus.Grant, 0);
    chk("ab_value0", bus.ValueToPay, 0);
    chk("ab_min0", bus.MinutesLeft, 0);
    cyc(3);
    chk("ab_no_run", bus.Active, 0);

    // B alone: empty payment ignored, then all buttons at once
    bus.ClientB = 1'b1;
    cyc(2);
    chk("b_grant", bus.Grant, 2);
    pay();
    chk("b_pay_ignored", bus.Active, 0);
    chk("b_pay_grant", bus.Grant, 2);
    {bus.Button2Hours, bus.Button1Hour, bus.Button30Min} = 3'b111;
    cyc(2);
    chk("all_value", bus.ValueToPay, 13);
    chk("all_min", bus.MinutesLeft, 210);
    chk("all_p", bus.P, 1);
    cyc(10);
    chk("held_value", bus.ValueToPay, 13);
    chk("held_min", bus.MinutesLeft, 210);
    bus.ClientB = 1'b0;
    {bus.Button2Hours, bus.Button1Hour, bus.Button30Min} = 3'b000;
    cyc(2);
    chk("b_abort_grant", bus.Grant, 0);
    chk("b_abort_min", bus.MinutesLeft, 0);

    // cap at 240 min
    bus.ClientB = 1'b1;
    cyc(2);
    chk("cap_grant", bus.Grant, 2);
    press(3'b100);
    chk("cap_v1", bus.ValueToPay, 7);
    press(3'b100);
    chk("cap_min2", bus.MinutesLeft, 240);
    chk("cap_v2", bus.ValueToPay, 14);
    press(3'b001);
    chk("cap_min3", bus.MinutesLeft, 240);
    chk("cap_v3", bus.ValueToPay, 14);
    press(3'b010);
    chk("cap_v4", bus.ValueToPay, 14);
    pay();
    chk("cap_active", bus.Active, 1);
    chk("cap_run_min", bus.MinutesLeft, 240);
    bus.ClientA = 1'b1;
    cyc(5);
    chk("no_preempt", bus.Grant, 2);
    run_out(955, "cap_run_len");

    // round-robin with both stations requesting
    cyc(2);
    chk("rr_a", bus.Grant, 1);
    press(3'b001);
    pay();
    run_out(120, "rr_a_len");
    cyc(2);
    chk("rr_b", bus.Grant, 2);
    press(3'b001);
    pay();
    run_out(120, "rr_b_len");
    cyc(2);
    chk("rr_a2", bus.Grant, 1);
    press(3'b001);
    pay();
    run_out(120, "rr_a2_len");
    cyc(2);
    chk("rr_b2", bus.Grant, 2);

    // reset in the middle of B's session
    press(3'b010);
    pay();
    chk("rst_run_active", bus.Active, 1);
    cyc(120);
    chk("rst_run_min30", bus.MinutesLeft, 30);
    ResetN = 1'b0;
    #1;
    chk("mid_rst_grant", bus.Grant, 0);
    chk("mid_rst_value", bus.ValueToPay, 0);
    chk("mid_rst_min", bus.MinutesLeft, 0);
    chk("mid_rst_p", bus.P, 0);
    chk("mid_rst_active", bus.Active, 0);
    cyc(1);
    ResetN = 1'b1;
    cyc(2);
    chk("post_rst_a_wins", bus.Grant, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
